// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the PC register and the fetch unit top.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with hold / +4 / redirect next-PC selection.
// Redirect targets are forced to word alignment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = align_word(target);
        else if (advance)
            pc_next = pc + PC_STEP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, stale-response drop after redirect,
// and a held instruction buffer presented to the IF->ID register.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValidF,
    output logic        FetchBusyF
);

    fetch_state_t state;
    logic [31:0]  instr_q;
    logic [31:0]  pc;
    logic         advance;

    // PC only steps when the held instruction is released downstream
    assign advance = (state == S_VALID) && !PCSrcE && !StallF;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .redirect(PCSrcE),
        .advance (advance),
        .target  (PCTargetE),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_REQ;
            instr_q <= NOP_INSTR;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (PCSrcE)
                        state <= imem_req_ready ? S_DROP : S_REQ;
                    else if (imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        state <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        instr_q <= imem_rsp_data;
                        state   <= S_VALID;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid)
                        state <= S_REQ;
                end
                S_VALID: begin
                    if (PCSrcE || !StallF)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign FetchValidF    = (state == S_VALID);
    assign FetchBusyF     = ~FetchValidF;
    assign InstrF         = FetchValidF ? instr_q : NOP_INSTR;
    assign PCF            = pc;
    assign PCPlus4F       = pc + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetches with a
// scoreboard of accepted requests, plus redirect/reset corner sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;
    logic        FetchBusyF;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (StallF),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .InstrF        (InstrF),
        .PCF           (PCF),
        .PCPlus4F      (PCPlus4F),
        .FetchValidF   (FetchValidF),
        .FetchBusyF    (FetchBusyF)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int          rdy_dly;
        int          lat;
        int          stall;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 8);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] pc, input bit push);
        chk("acc_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("acc_req_addr", imem_req_addr, pc);
        imem_req_ready = 1'b1;
        if (push)
            sb.push_back('{pc, mem_word(pc)});
        step();
        imem_req_ready = 1'b0;
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty got pc %h", nm, PCF);
        end else begin
            e = sb.pop_front();
            chk({nm, "_valid"}, {31'd0, FetchValidF}, 32'd1);
            chk({nm, "_instr"}, InstrF, e.instr);
            chk({nm, "_pc"}, PCF, e.pc);
            chk({nm, "_pc4"}, PCPlus4F, e.pc + 32'd4);
        end
    endtask

    task automatic fetch_one(input int rd, input int lat, input int st,
                             input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        for (int i = 0; i < rd; i++) begin
            step();
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_addr", imem_req_addr, pc);
            chk("hold_busy", {31'd0, FetchBusyF}, 32'd1);
        end
        accept(pc, 1'b1);
        chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_nop", InstrF, NOP);
        for (int i = 1; i < lat; i++) begin
            step();
            chk("lat_nop", InstrF, NOP);
            chk("lat_busy", {31'd0, FetchBusyF}, 32'd1);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pc);
        StallF         = (st > 0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pop_check("fetch");
        for (int k = 0; k < st; k++) begin
            step();
            chk("stall_valid", {31'd0, FetchValidF}, 32'd1);
            chk("stall_instr", InstrF, mem_word(pc));
            chk("stall_pc", PCF, pc);
            chk("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        StallF = 1'b0;
        step();
        chk("next_req", {31'd0, imem_req_valid}, 32'd1);
        chk("next_addr", imem_req_addr, nxt);
        chk("next_busy", {31'd0, FetchBusyF}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1, 0, 32'h0000_0000};
        vecs[1] = '{0, 1, 3, 32'h0000_0004};
        vecs[2] = '{0, 2, 0, 32'h0000_0008};
        vecs[3] = '{2, 3, 1, 32'h0000_000C};
        vecs[4] = '{5, 1, 0, 32'h0000_0010};

        reset          = 1'b0;
        StallF         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_valid", {31'd0, FetchValidF}, 32'd0);
        chk("rst_busy", {31'd0, FetchBusyF}, 32'd1);
        chk("rst_pc4", PCPlus4F, 32'd4);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 5; v++)
            fetch_one(vecs[v].rdy_dly, vecs[v].lat, vecs[v].stall,
                      vecs[v].exp_pc);

        // redirect while waiting; response two cycles later is stale
        accept(32'h14, 1'b0);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        step();
        PCSrcE = 1'b0;
        chk("drop_noreq", {31'd0, imem_req_valid}, 32'd0);
        chk("drop_nop", InstrF, NOP);
        step();
        chk("drop_nop2", InstrF, NOP);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("drop_addr", imem_req_addr, 32'h0000_0100);
        chk("drop_req", {31'd0, imem_req_valid}, 32'd1);
        chk("drop_instr", InstrF, NOP);
        chk("drop_valid", {31'd0, FetchValidF}, 32'd0);
        fetch_one(0, 1, 0, 32'h0000_0100);

        // redirect and response on the same edge
        accept(32'h104, 1'b0);
        PCSrcE         = 1'b1;
        PCTargetE      = 32'h0000_0200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        PCSrcE         = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("same_addr", imem_req_addr, 32'h0000_0200);
        chk("same_req", {31'd0, imem_req_valid}, 32'd1);
        chk("same_valid", {31'd0, FetchValidF}, 32'd0);
        step();
        chk("same_still", {31'd0, FetchValidF}, 32'd0);

        // redirect coinciding with request handshake, misaligned target
        imem_req_ready = 1'b1;
        PCSrcE         = 1'b1;
        PCTargetE      = 32'hFFFF_FFFE;
        step();
        imem_req_ready = 1'b0;
        PCSrcE         = 1'b0;
        chk("reqdrop_noreq", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("align_addr", imem_req_addr, 32'hFFFF_FFFC);
        fetch_one(0, 1, 0, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // redirect wins over stall in the valid state
        accept(32'h0, 1'b1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h0);
        StallF         = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        pop_check("prio");
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0303;
        step();
        PCSrcE = 1'b0;
        StallF = 1'b0;
        chk("prio_addr", imem_req_addr, 32'h0000_0300);
        chk("prio_valid", {31'd0, FetchValidF}, 32'd0);

        // asynchronous reset in the middle of a wait
        accept(32'h300, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("mrst_addr", imem_req_addr, 32'h0);
        chk("mrst_req", {31'd0, imem_req_valid}, 32'd1);
        chk("mrst_instr", InstrF, NOP);
        chk("mrst_busy", {31'd0, FetchBusyF}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        fetch_one(0, 1, 0, 32'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
